// File: rtl/obc_acc_seq.sv
// obc_acc_seq -- sequencer for the shared ACC_W-bit adder in the OBC DFT
// datapath. It walks the NBITS bit-planes of one inner product MSB-first,
// shift-accumulating the LUT partial sums, then adds the OBC offset once.
// The adder is external and purely combinational.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   start, offset         begin request (IDLE only) and offset constant
//   busy                  high outside IDLE
//   bit_idx               bit-plane select to the LUT, NBITS-1 down to 0
//   lut_valid/ready/data  partial-sum handshake from the LUT bank
//   add_a, add_b, add_sum external adder operands and result
//   res_valid/ready       result handshake, result = inner product
//   ovf                   (OBC_OVF_DETECT_EN only) sticky signed overflow
//
// Optional feature macro: OBC_OVF_DETECT_EN adds the ovf output.
module obc_acc_seq #(
    parameter int ACC_W = 32,
    parameter int NBITS = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] offset,
    output logic             busy,
    output logic [IDX_W-1:0] bit_idx,
    input  logic             lut_valid,
    input  logic [ACC_W-1:0] lut_data,
    output logic             lut_ready,
    output logic [ACC_W-1:0] add_a,
    output logic [ACC_W-1:0] add_b,
    input  logic [ACC_W-1:0] add_sum,
    output logic             res_valid,
    input  logic             res_ready,
`ifdef OBC_OVF_DETECT_EN
    output logic             ovf,
`endif
    output logic [ACC_W-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OFFS = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NBITS - 1);

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] offs_q;
    logic             beat;

    assign busy      = (state != S_IDLE);
    assign lut_ready = (state == S_RUN);
    assign res_valid = (state == S_DONE);
    assign beat      = lut_valid && lut_ready;

    // Operand steering. The sign plane carries negative weight in the
    // two's-complement input word, so its partial sum is subtracted.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            S_RUN: begin
                add_a = {acc[ACC_W-2:0], 1'b0};
                add_b = (bit_idx == TOP_IDX) ? (ACC_W'(0) - lut_data) : lut_data;
            end
            S_OFFS: begin
                add_a = acc;
                add_b = offs_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            offs_q  <= '0;
            bit_idx <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        offs_q  <= offset;
                        acc     <= '0;
                        bit_idx <= TOP_IDX;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Stalls (lut_valid low) simply hold everything.
                    if (beat) begin
                        acc <= add_sum;
                        if (bit_idx == '0) state <= S_OFFS;
                        else               bit_idx <= bit_idx - 1'b1;
                    end
                end
                S_OFFS: begin
                    acc    <= add_sum;
                    result <= add_sum;
                    state  <= S_DONE;
                end
                default: begin
                    // start is deliberately not looked at here, even on the
                    // handshake cycle.
                    if (res_ready) state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef OBC_OVF_DETECT_EN
    logic step_ovf;
    logic step_live;

    // Signed overflow: operands agree in sign, sum disagrees.
    assign step_ovf  = (add_a[ACC_W-1] == add_b[ACC_W-1]) &&
                       (add_sum[ACC_W-1] != add_a[ACC_W-1]);
    assign step_live = (state == S_OFFS) || beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          ovf <= 1'b0;
        else if (state == S_IDLE && start) ovf <= 1'b0;
        else if (step_live && step_ovf)    ovf <= 1'b1;
    end
`endif

endmodule
